// File: rtl/multicycle_ctrl_fsm_pkg.sv
// multicycle_ctrl_fsm_pkg: state and datapath-select encodings for the lw/sw/beq multicycle controller
package multicycle_ctrl_fsm_pkg;
    typedef enum logic [2:0] {
        FETCH    = 3'd0,
        DECODE   = 3'd1,
        MEMADR   = 3'd2,
        MEMREAD  = 3'd3,
        MEMWB    = 3'd4,
        MEMWRITE = 3'd5,
        BEQ      = 3'd6,
        FAULT    = 3'd7
    } state_t;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;
    localparam logic [1:0] SRC_B_RS2   = 2'b00;
    localparam logic [1:0] SRC_B_IMM   = 2'b01;
    localparam logic [1:0] SRC_B_FOUR  = 2'b10;
    localparam logic [1:0] ALU_ADD     = 2'b00;
    localparam logic [1:0] ALU_SUB     = 2'b01;
    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_RDATA   = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;
    function automatic logic is_req(state_t s);
        return s == FETCH || s == MEMREAD || s == MEMWRITE;
    endfunction
endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// multicycle_ctrl_fsm_if: controller-to-datapath/memory control bundle
interface multicycle_ctrl_fsm_if;
    import multicycle_ctrl_fsm_pkg::*;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic       retire;
    logic       illegal;
    logic       bus_err;
    state_t     state;
    modport master (
        input  opcode, zero, mem_ready,
        output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, alu_op, result_src, retire, illegal, bus_err, state
    );
    modport slave (
        output opcode, zero, mem_ready,
        input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, alu_op, result_src, retire, illegal, bus_err, state
    );
endinterface

// File: rtl/multicycle_ctrl_fsm_mem_wait_timer.sv
// multicycle_ctrl_fsm_mem_wait_timer: counts memory wait cycles and flags the timeout limit
module multicycle_ctrl_fsm_mem_wait_timer #(
    parameter int LIMIT = 16,
    parameter int CNT_W = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic limit_hit
);
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (!rst_n || clear) cnt <= '0;
        else if (count_en) cnt <= cnt + CNT_W'(1);
    end
    assign limit_hit = cnt == CNT_W'(LIMIT - 1);
endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: fetch/decode/address/memory/writeback sequencer for lw, sw and beq
module multicycle_ctrl_fsm
    import multicycle_ctrl_fsm_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input logic                  clk,
    input logic                  rst_n,
    multicycle_ctrl_fsm_if.master bus
);
    state_t     state, next;
    logic [6:0] op_q;
    logic       illegal_q, bus_err_q, req, limit_hit, timeout;
    assign req     = is_req(state);
    assign timeout = req && limit_hit && !bus.mem_ready;
    // Counter sits at zero outside request states, so every request state is entered with a fresh count
    multicycle_ctrl_fsm_mem_wait_timer #(.LIMIT(MEM_TIMEOUT), .CNT_W(CNT_W)) u_wait (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (!req || bus.mem_ready),
        .count_en (req && !bus.mem_ready),
        .limit_hit(limit_hit)
    );
    always_comb begin
        next = state;
        case (state)
            FETCH:    next = bus.mem_ready ? DECODE : FETCH;
            DECODE:   next = (bus.opcode == OP_LW || bus.opcode == OP_SW) ? MEMADR :
                             bus.opcode == OP_BEQ ? BEQ : FETCH;
            MEMADR:   next = op_q == OP_SW ? MEMWRITE : op_q == OP_LW ? MEMREAD : FETCH;
            MEMREAD:  next = bus.mem_ready ? MEMWB : MEMREAD;
            MEMWRITE: next = bus.mem_ready ? FETCH : MEMWRITE;
            MEMWB:    next = FETCH;
            BEQ:      next = FETCH;
            default:  next = state;
        endcase
        if (timeout) next = FAULT;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= FETCH;
            op_q      <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state <= next;
            if (state == DECODE) op_q <= bus.opcode;
            if (state == DECODE && next == FETCH) illegal_q <= 1'b1;
            if (timeout) bus_err_q <= 1'b1;
        end
    end
    always_comb begin
        bus.mem_req    = 1'b0;
        bus.mem_write  = 1'b0;
        bus.adr_src    = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.reg_write  = 1'b0;
        bus.alu_src_a  = SRC_A_PC;
        bus.alu_src_b  = SRC_B_RS2;
        bus.alu_op     = ALU_ADD;
        bus.result_src = RES_ALUOUT;
        bus.retire     = 1'b0;
        bus.illegal    = rst_n && illegal_q && state != FAULT;
        bus.bus_err    = rst_n && bus_err_q;
        bus.state      = rst_n ? state : FETCH;
        if (rst_n) begin
            case (state)
                FETCH: begin
                    bus.mem_req    = 1'b1;
                    bus.alu_src_b  = SRC_B_FOUR;
                    bus.result_src = RES_ALU;
                    bus.ir_write   = bus.mem_ready;
                    bus.pc_write   = bus.mem_ready;
                end
                DECODE: begin
                    bus.alu_src_a = SRC_A_OLDPC;
                    bus.alu_src_b = SRC_B_IMM;
                end
                MEMADR: begin
                    bus.alu_src_a = SRC_A_RS1;
                    bus.alu_src_b = SRC_B_IMM;
                end
                MEMREAD: begin
                    bus.mem_req = 1'b1;
                    bus.adr_src = 1'b1;
                end
                MEMWB: begin
                    bus.reg_write  = 1'b1;
                    bus.result_src = RES_RDATA;
                    bus.retire     = 1'b1;
                end
                MEMWRITE: begin
                    bus.mem_req   = 1'b1;
                    bus.mem_write = 1'b1;
                    bus.adr_src   = 1'b1;
                    bus.retire    = bus.mem_ready;
                end
                BEQ: begin
                    bus.alu_src_a  = SRC_A_RS1;
                    bus.alu_src_b  = SRC_B_RS2;
                    bus.alu_op     = ALU_SUB;
                    bus.result_src = RES_ALUOUT;
                    bus.pc_write   = bus.zero;
                    bus.retire     = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
